// File: rtl/demux_dispatch_controller_pkg.sv
// Shared encodings and small helpers for the demux dispatch controller.
package demux_dispatch_controller_pkg;

    // Demux select encodings; SEL_NONE parks the demux with no destination.
    localparam logic [1:0] SEL_OUT1  = 2'd0;
    localparam logic [1:0] SEL_OUT2  = 2'd1;
    localparam logic [1:0] SEL_OUT3  = 2'd2;
    localparam logic [1:0] SEL_NONE  = 2'd3;

    // Destination code requesting round-robin routing.
    localparam logic [1:0] DEST_AUTO = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Round-robin pointer sequence 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] ptr);
        return (ptr == SEL_OUT3) ? SEL_OUT1 : ptr + 2'd1;
    endfunction

    // One-hot sink vector for a select value; SEL_NONE maps to no sink.
    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            SEL_OUT1: oh = 3'b001;
            SEL_OUT2: oh = 3'b010;
            SEL_OUT3: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_dispatch_controller_if.sv
// Handshake and status bundle between the byte source / sinks and the controller.
interface demux_dispatch_controller_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_dest;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] demux_data;
    logic [1:0]        demux_sel;
    logic [2:0]        out_valid;
    logic [2:0]        out_ready;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt1;
    logic [CNT_W-1:0]  cnt2;
    logic [CNT_W-1:0]  cnt3;
    logic              busy;

    // Environment side: upstream producer, sinks and counter control.
    modport master (
        output in_data, in_dest, in_valid, out_ready, cnt_clr,
        input  in_ready, demux_data, demux_sel, out_valid, cnt1, cnt2, cnt3, busy
    );

    // Controller side.
    modport slave (
        input  in_data, in_dest, in_valid, out_ready, cnt_clr,
        output in_ready, demux_data, demux_sel, out_valid, cnt1, cnt2, cnt3, busy
    );
endinterface

// File: rtl/demux_dispatch_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear dominates increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count completions, holding at MAX instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + ONE;
        end
    end
endmodule

// File: rtl/demux_dispatch_controller.sv
// Dispatch controller: one-entry byte holding register in front of a 1:3 demux,
// explicit or round-robin destination, per-sink completion counters.
module demux_dispatch_controller
    import demux_dispatch_controller_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    demux_dispatch_controller_if.slave    bus
);
    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic [1:0]        r_sel, w_sel_nxt;
    logic [2:0]        r_valid, w_valid_nxt;
    logic [1:0]        r_rr_ptr, w_rr_nxt;
    logic [1:0]        w_dest;
    logic              w_sel_ready;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_complete;
    logic [2:0]        w_inc;
    logic [CNT_W-1:0]  w_cnt1, w_cnt2, w_cnt3;

    // Ready of the sink currently being served; parked select never reports ready.
    always_comb begin
        w_sel_ready = 1'b0;
        case (r_sel)
            SEL_OUT1: w_sel_ready = bus.out_ready[0];
            SEL_OUT2: w_sel_ready = bus.out_ready[1];
            SEL_OUT3: w_sel_ready = bus.out_ready[2];
            default:  w_sel_ready = 1'b0;
        endcase
    end

    // The holding register frees up in the same cycle its byte is taken, giving 1 byte/cycle.
    assign w_in_ready = reset_n & ((r_state == ST_IDLE) | w_sel_ready);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_complete = (r_state == ST_HOLD) & w_sel_ready;
    assign w_dest     = (bus.in_dest == DEST_AUTO) ? r_rr_ptr : bus.in_dest;

    // Next-state and holding-register update; accept takes priority over going idle.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_valid;
        w_rr_nxt    = r_rr_ptr;
        if (w_accept) begin
            w_state_nxt = ST_HOLD;
            w_data_nxt  = bus.in_data;
            w_sel_nxt   = w_dest;
            w_valid_nxt = sel_onehot(w_dest);
            if (bus.in_dest == DEST_AUTO) begin
                w_rr_nxt = rr_next(r_rr_ptr);
            end
        end else if (w_complete) begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = SEL_NONE;
            w_valid_nxt = 3'b000;
        end
    end

    // State and holding registers; reset drops any held byte.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_data   <= '0;
            r_sel    <= SEL_NONE;
            r_valid  <= 3'b000;
            r_rr_ptr <= SEL_OUT1;
        end else begin
            r_state  <= w_state_nxt;
            r_data   <= w_data_nxt;
            r_sel    <= w_sel_nxt;
            r_valid  <= w_valid_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    assign w_inc = w_complete ? sel_onehot(r_sel) : 3'b000;

    sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk(clk), .reset_n(reset_n), .clr(bus.cnt_clr), .inc(w_inc[0]), .count(w_cnt1)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt2 (
        .clk(clk), .reset_n(reset_n), .clr(bus.cnt_clr), .inc(w_inc[1]), .count(w_cnt2)
    );
    sat_counter #(.CNT_W(CNT_W)) u_cnt3 (
        .clk(clk), .reset_n(reset_n), .clr(bus.cnt_clr), .inc(w_inc[2]), .count(w_cnt3)
    );

    assign bus.in_ready   = w_in_ready;
    assign bus.demux_data = r_data;
    assign bus.demux_sel  = r_sel;
    assign bus.out_valid  = r_valid;
    assign bus.cnt1       = w_cnt1;
    assign bus.cnt2       = w_cnt2;
    assign bus.cnt3       = w_cnt3;
    assign bus.busy       = (r_state == ST_HOLD);
endmodule

// File: doc/demux_dispatch_controller.md
Name: demux_dispatch_controller

Overview:
Sequences the 8-bit one-to-three demultiplexer datapath. Accepts bytes from a single upstream producer over a valid/ready handshake and holds each byte in a one-entry register. Resolves the destination (explicit or round-robin) and drives the demux select, one-hot per-sink valids and per-sink transfer counters. Sits between the upstream byte source and the demux plus its three consumers.

Parameters:
DATA_W, 8, width of the data byte and of the demux data path.
CNT_W, 8, width of each per-sink saturating transfer counter.

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
in_data  input  DATA_W  upstream byte
in_dest  input  2  destination: 0=out1, 1=out2, 2=out3, 3=auto (round-robin)
in_valid  input  1  upstream byte valid
in_ready  output  1  controller can accept this cycle
demux_data  output  DATA_W  held byte, drives the demux data input
demux_sel  output  2  demux select: 0=out1, 1=out2, 2=out3, 3=no destination (parked)
out_valid  output  3  one-hot sink valid; bit0=out1, bit1=out2, bit2=out3
out_ready  input  3  per-sink ready, same bit order
cnt_clr  input  1  synchronous clear of all transfer counters
cnt1  output  CNT_W  completed transfers to out1
cnt2  output  CNT_W  completed transfers to out2
cnt3  output  CNT_W  completed transfers to out3
busy  output  1  a byte is held (state HOLD)

Behaviour:
- Reset values (reset_n=0 at a rising edge):
  - State=IDLE; demux_data=0; demux_sel=3; out_valid=000.
  - rr_ptr=0; cnt1..cnt3=0; busy=0.
  - in_ready=0 while reset_n=0.
- States: IDLE (nothing held), HOLD (byte held for sink d).
- in_ready is combinational: 1 in IDLE; in HOLD equals out_ready[d].
- Accept occurs when in_valid & in_ready.
  - Capture in_data.
  - Resolve d: in_dest if 0..2; rr_ptr if 3, then rr_ptr advances 0→1→2→0.
  - rr_ptr changes only on auto accepts.
- Latency: the byte and demux_sel=d appear, with out_valid one-hot at d, on the cycle after accept.
- HOLD:
  - demux_data, demux_sel and out_valid are registered and stay stable until out_ready[d]=1; valid is never retracted.
  - out_ready bits for non-selected sinks are ignored.
- Completion (HOLD & out_ready[d]): cnt for sink d increments, saturating at 2^CNT_W-1 (no wrap).
  - If an accept happens in the same cycle: stay in HOLD with the new byte and destination. Sustained throughput is 1 byte/cycle.
  - Otherwise go to IDLE: demux_sel=3, out_valid=000, demux_data holds its last value.
- Both fields are sampled only on accept: in_dest=3 with in_valid=0 does not move rr_ptr, and in_dest is ignored while not accepting.
- cnt_clr=1 clears all counters; it wins over a coincident completion (the counter reads 0 next cycle).
- Reset mid-HOLD: the held byte is dropped, no completion is counted and all reset values apply next cycle.
- busy = (state==HOLD).

Decomposition:
- Shared package/include:
  - SEL_OUT1=2'd0, SEL_OUT2=2'd1, SEL_OUT3=2'd2, SEL_NONE=2'd3.
  - DEST_AUTO=2'd3.
  - State encodings ST_IDLE=1'b0, ST_HOLD=1'b1.
- One sub-module, sat_counter (CNT_W parameter; inputs clk, reset_n, clr, inc; output count), instantiated three times.
- The controller does not instantiate the demux; the top level wires demux_data and demux_sel to it.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with in_valid=1 → in_ready=0, demux_sel=3, out_valid=000, cnt1..3=0.
2. Explicit route: send 0xA5 with in_dest=1 while out_ready=111 → next cycle demux_data=0xA5, demux_sel=1, out_valid=010; following cycle IDLE, cnt2=1.
3. Round-robin back-to-back: send 0x01, 0x02, 0x03, 0x04 with in_dest=3, one per cycle, out_ready=111 → sels 0,1,2,0 on consecutive cycles; in_ready stays 1; cnt1=2, cnt2=1, cnt3=1.
4. Backpressure: send 0x3C to dest 2 with out_ready[2]=0 for 5 cycles → out_valid=100, data 0x3C stable, in_ready=0 throughout; raising out_ready[0] changes nothing; raising out_ready[2] completes it, cnt3=1.
5. Saturation and clear: 260 completions to dest 0 → cnt1=255; assert cnt_clr in the same cycle as a completion → cnt1=0.
6. Reset mid-HOLD: hold 0x77 for dest 1 with out_ready=000, then pulse reset_n=0 → next cycle out_valid=000, demux_sel=3, cnt2=0, rr_ptr=0.
